pcie_msg_queue_notifier: RTL and testbench

Downstream companion of `pcie_msg_receiver`. Consumes each completed-assembly event (tag, tag-owner, source endpoint ID, length in beats), binds the message to one of 15 RX queues keyed by {src_id, TO, tag}, and advances that queue's 64-beat write pointer. It then raises per-queue interrupt status with host write-1-to-clear and drives the aggregated message interrupt. It supplies the Q_INTR_STATUS, Q_DATA_WPTR and debug SFR values read by software.

---
 rtl/pcie_msg_pkg.sv | 30 +++
 rtl/pcie_msg_queue_lookup.sv | 34 +++
 rtl/pcie_msg_queue_notifier.sv | 176 +++++++++++++++++
 tb/tb_pcie_msg_queue_notifier.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_msg_pkg.sv
// rtl/pcie_msg_pkg.sv - shared constants, key/state types and helpers for the RX queue notifier
package pcie_msg_pkg;

  localparam int NUM_Q   = 15;
  localparam int Q_BEATS = 64;
  localparam int IDX_W   = 4;
  localparam int WPTR_W  = 6;
  localparam int LEN_W   = 12;

  localparam int DBG_DROP_LSB   = 24;
  localparam int DBG_LENERR_LSB = 16;
  localparam int DBG_ALLOC_LSB  = 0;

  typedef struct packed {
    logic [7:0] src_id;
    logic       tag_owner;
    logic [2:0] tag;
  } msg_key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pcie_msg_queue_lookup.sv
// rtl/pcie_msg_queue_lookup.sv - combinational key match and lowest-free queue search
module pcie_msg_queue_lookup
  import pcie_msg_pkg::*;
#(
  parameter int NQ = pcie_msg_pkg::NUM_Q
) (
  input  msg_key_t                 key,
  input  msg_key_t [NQ-1:0]        keys,
  input  logic     [NQ-1:0]        alloc_valid,
  output logic                     hit,
  output logic     [IDX_W-1:0]     hit_idx,
  output logic                     free_avail,
  output logic     [IDX_W-1:0]     free_idx
);

  // Walk from the top so the lowest-numbered match/free slot is the last write.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_avail = 1'b0;
    free_idx   = '0;
    for (int i = NQ - 1; i >= 0; i--) begin
      if (alloc_valid[i] && (keys[i] == key)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!alloc_valid[i]) begin
        free_avail = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pcie_msg_queue_notifier.sv
// rtl/pcie_msg_queue_notifier.sv - binds assembled messages to RX queues, advances write
// pointers and raises per-queue W1C interrupt status.
module pcie_msg_queue_notifier
  import pcie_msg_pkg::*;
#(
  parameter int NUM_Q   = pcie_msg_pkg::NUM_Q,
  parameter int Q_BEATS = pcie_msg_pkg::Q_BEATS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    evt_valid,
  output logic                    evt_ready,
  input  logic [2:0]              evt_tag,
  input  logic                    evt_to,
  input  logic [7:0]              evt_src_id,
  input  logic [LEN_W-1:0]        evt_len,
  input  logic [31:0]             intr_clear,
  input  logic [NUM_Q-1:0]        intr_en,
  output logic [31:0]             q_intr_status,
  output logic [31:0]             q_data_wptr,
  output logic [NUM_Q*WPTR_W-1:0] q_wptr_flat,
  output logic [NUM_Q-1:0]        q_alloc_valid,
  output logic [31:0]             dbg,
  output logic                    o_msg_interrupt
);

  localparam logic [WPTR_W-1:0] WPTR_MASK = WPTR_W'(Q_BEATS - 1);

  state_e                          state_q, state_d;
  logic                            evt_ready_q, evt_ready_d;
  msg_key_t                        key_q, key_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_Q-1:0]                alloc_q, alloc_d;
  logic [NUM_Q-1:0]                status_q, status_d;
  msg_key_t [NUM_Q-1:0]            keys_q, keys_d;
  logic [NUM_Q-1:0][WPTR_W-1:0]    wptr_q, wptr_d;
  logic [IDX_W-1:0]                last_idx_q, last_idx_d;
  logic [WPTR_W-1:0]               last_wptr_q, last_wptr_d;
  logic [7:0]                      drop_cnt_q, drop_cnt_d;
  logic [7:0]                      len_err_cnt_q, len_err_cnt_d;
  logic                            irq_q, irq_d;

  logic                            lk_hit, lk_free;
  logic [IDX_W-1:0]                lk_hit_idx, lk_free_idx;
  logic [WPTR_W-1:0]               wptr_next;
  logic                            len_bad;
  logic [3:0]                      alloc_cnt;
  logic [NUM_Q-1:0]                clr_vec;
  logic                            unused_clear_hi;

  assign clr_vec         = intr_clear[NUM_Q-1:0];
  assign unused_clear_hi = &{1'b0, intr_clear[31:NUM_Q]};

  pcie_msg_queue_lookup #(.NQ(NUM_Q)) u_lookup (
    .key         (key_q),
    .keys        (keys_q),
    .alloc_valid (alloc_q),
    .hit         (lk_hit),
    .hit_idx     (lk_hit_idx),
    .free_avail  (lk_free),
    .free_idx    (lk_free_idx)
  );

  assign len_bad   = (len_q == '0) || (len_q > LEN_W'(Q_BEATS));
  // A full-depth message (len == Q_BEATS) wraps back onto the same pointer.
  assign wptr_next = (wptr_q[idx_q] + len_q[WPTR_W-1:0]) & WPTR_MASK;

  always_comb begin
    alloc_cnt = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      alloc_cnt = alloc_cnt + 4'(alloc_q[i]);
    end
  end

  always_comb begin
    state_d       = state_q;
    evt_ready_d   = evt_ready_q;
    key_d         = key_q;
    len_d         = len_q;
    idx_d         = idx_q;
    alloc_d       = alloc_q & ~clr_vec;
    status_d      = status_q & ~clr_vec;
    keys_d        = keys_q;
    wptr_d        = wptr_q;
    last_idx_d    = last_idx_q;
    last_wptr_d   = last_wptr_q;
    drop_cnt_d    = drop_cnt_q;
    len_err_cnt_d = len_err_cnt_q;
    irq_d         = |(status_q & intr_en);

    case (state_q)
      ST_IDLE: begin
        evt_ready_d = 1'b1;
        if (evt_valid && evt_ready_q) begin
          key_d       = '{src_id: evt_src_id, tag_owner: evt_to, tag: evt_tag};
          len_d       = evt_len;
          state_d     = ST_LOOKUP;
          evt_ready_d = 1'b0;
        end
      end
      ST_LOOKUP: begin
        if (len_bad) begin
          len_err_cnt_d = sat_inc8(len_err_cnt_q);
          state_d       = ST_IDLE;
          evt_ready_d   = 1'b1;
        end else if (lk_hit || lk_free) begin
          idx_d   = lk_hit ? lk_hit_idx : lk_free_idx;
          state_d = ST_UPDATE;
        end else begin
          drop_cnt_d  = sat_inc8(drop_cnt_q);
          state_d     = ST_IDLE;
          evt_ready_d = 1'b1;
        end
      end
      ST_UPDATE: begin
        // Applied after the clear mask so a same-cycle clear loses to the set.
        alloc_d[idx_q]  = 1'b1;
        status_d[idx_q] = 1'b1;
        keys_d[idx_q]   = key_q;
        wptr_d[idx_q]   = wptr_next;
        last_idx_d      = idx_q;
        last_wptr_d     = wptr_next;
        state_d         = ST_IDLE;
        evt_ready_d     = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        evt_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      evt_ready_q   <= 1'b1;
      key_q         <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      alloc_q       <= '0;
      status_q      <= '0;
      keys_q        <= '0;
      wptr_q        <= '0;
      last_idx_q    <= '0;
      last_wptr_q   <= '0;
      drop_cnt_q    <= '0;
      len_err_cnt_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      evt_ready_q   <= evt_ready_d;
      key_q         <= key_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      alloc_q       <= alloc_d;
      status_q      <= status_d;
      keys_q        <= keys_d;
      wptr_q        <= wptr_d;
      last_idx_q    <= last_idx_d;
      last_wptr_q   <= last_wptr_d;
      drop_cnt_q    <= drop_cnt_d;
      len_err_cnt_q <= len_err_cnt_d;
      irq_q         <= irq_d;
    end
  end

  assign evt_ready       = evt_ready_q;
  assign q_intr_status   = {{(32-NUM_Q){1'b0}}, status_q};
  assign q_data_wptr     = {4'b0, last_idx_q, 18'b0, last_wptr_q};
  assign q_wptr_flat     = wptr_q;
  assign q_alloc_valid   = alloc_q;
  assign dbg             = {drop_cnt_q, len_err_cnt_q, 12'b0, alloc_cnt};
  assign o_msg_interrupt = irq_q;

endmodule

// File: tb/tb_pcie_msg_queue_notifier.sv
// tb/tb_pcie_msg_queue_notifier.sv - directed scoreboard bench for the RX queue notifier
module tb_pcie_msg_queue_notifier;
  import pcie_msg_pkg::*;

  localparam int NQ = 15;
  localparam int QB = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               evt_valid;
  logic               evt_ready;
  logic [2:0]         evt_tag;
  logic               evt_to;
  logic [7:0]         evt_src_id;
  logic [11:0]        evt_len;
  logic [31:0]        intr_clear;
  logic [NQ-1:0]      intr_en;
  logic [31:0]        q_intr_status;
  logic [31:0]        q_data_wptr;
  logic [NQ*6-1:0]    q_wptr_flat;
  logic [NQ-1:0]      q_alloc_valid;
  logic [31:0]        dbg;
  logic               o_msg_interrupt;

  pcie_msg_queue_notifier #(.NUM_Q(NQ), .Q_BEATS(QB)) dut (
    .clk             (clk),
    .rst             (rst),
    .evt_valid       (evt_valid),
    .evt_ready       (evt_ready),
    .evt_tag         (evt_tag),
    .evt_to          (evt_to),
    .evt_src_id      (evt_src_id),
    .evt_len         (evt_len),
    .intr_clear      (intr_clear),
    .intr_en         (intr_en),
    .q_intr_status   (q_intr_status),
    .q_data_wptr     (q_data_wptr),
    .q_wptr_flat     (q_wptr_flat),
    .q_alloc_valid   (q_alloc_valid),
    .dbg             (dbg),
    .o_msg_interrupt (o_msg_interrupt)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [9:0]  sb[$];
  logic [NQ-1:0] m_alloc;
  logic [NQ-1:0] m_status;
  logic [11:0] m_key [NQ];
  int          m_wptr [NQ];
  logic [7:0]  m_drop;
  logic [7:0]  m_lenerr;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_alloc  = '0;
    m_status = '0;
    m_drop   = '0;
    m_lenerr = '0;
    for (int i = 0; i < NQ; i++) begin
      m_key[i]  = '0;
      m_wptr[i] = 0;
    end
  endtask

  task automatic chk_all(input string pre);
    logic [NQ*6-1:0] exp_flat;
    logic [31:0]     exp_dbg;
    for (int i = 0; i < NQ; i++) exp_flat[6*i +: 6] = 6'(m_wptr[i]);
    exp_dbg = {m_drop, m_lenerr, 12'b0, 4'($countones(m_alloc))};
    chk({pre, "_status"}, 128'(q_intr_status), 128'({17'b0, m_status}));
    chk({pre, "_alloc"},  128'(q_alloc_valid), 128'(m_alloc));
    chk({pre, "_wptr"},   128'(q_wptr_flat),   128'(exp_flat));
    chk({pre, "_dbg"},    128'(dbg),           128'(exp_dbg));
    chk({pre, "_ready"},  128'(evt_ready),     128'(1'b1));
  endtask

  // Called just after a rising edge; returns just after the edge where the event retires.
  task automatic send(input logic [7:0] src, input logic to, input logic [2:0] tag,
                      input int len, input logic [31:0] upd_clr);
    int         idx;
    int         cyc;
    logic [9:0] exp;
    cyc = 0;
    while (evt_ready !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_before_send", 128'(evt_ready), 128'(1'b1));
    evt_src_id = src;
    evt_to     = to;
    evt_tag    = tag;
    evt_len    = 12'(len);
    evt_valid  = 1'b1;
    @(posedge clk); #1;
    evt_valid = 1'b0;
    chk("ready_low_after_accept", 128'(evt_ready), 128'(1'b0));
    if (len == 0 || len > QB) begin
      if (m_lenerr != 8'hFF) m_lenerr = m_lenerr + 8'd1;
      @(posedge clk); #1;
      chk_all("len_reject");
      return;
    end
    idx = -1;
    for (int i = 0; i < NQ; i++)
      if (m_alloc[i] && m_key[i] == {src, to, tag}) idx = i;
    if (idx < 0)
      for (int i = NQ - 1; i >= 0; i--)
        if (!m_alloc[i]) idx = i;
    if (idx < 0) begin
      if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
      @(posedge clk); #1;
      chk_all("drop");
      return;
    end
    m_wptr[idx] = (m_wptr[idx] + len) % QB;
    sb.push_back({4'(idx), 6'(m_wptr[idx])});
    @(posedge clk); #1;
    chk("ready_low_in_lookup", 128'(evt_ready), 128'(1'b0));
    intr_clear = upd_clr;
    @(posedge clk); #1;
    intr_clear = '0;
    m_status = m_status & ~upd_clr[NQ-1:0];
    m_alloc  = m_alloc & ~upd_clr[NQ-1:0];
    m_status[idx] = 1'b1;
    m_alloc[idx]  = 1'b1;
    m_key[idx]    = {src, to, tag};
    chk("sb_nonempty", 128'(sb.size() > 0), 128'(1'b1));
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      chk("data_wptr", 128'(q_data_wptr), 128'({4'b0, exp[9:6], 18'b0, exp[5:0]}));
    end
    chk_all("update");
  endtask

  task automatic apply_clear(input logic [31:0] clr);
    intr_clear = clr;
    @(posedge clk); #1;
    intr_clear = '0;
    m_status = m_status & ~clr[NQ-1:0];
    m_alloc  = m_alloc & ~clr[NQ-1:0];
    chk_all("clear");
  endtask

  initial begin
    rst        = 1'b1;
    evt_valid  = 1'b0;
    evt_tag    = '0;
    evt_to     = 1'b0;
    evt_src_id = '0;
    evt_len    = '0;
    intr_clear = '0;
    intr_en    = '1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk_all("reset");
    chk("reset_irq", 128'(o_msg_interrupt), 128'(1'b0));
    chk("reset_data_wptr", 128'(q_data_wptr), 128'(32'h0));

    send(8'h12, 1'b1, 3'd3, 5, 32'h0);
    chk("first_data_wptr", 128'(q_data_wptr), 128'(32'h0000_0005));
    chk("irq_not_yet", 128'(o_msg_interrupt), 128'(1'b0));
    @(posedge clk); #1;
    chk("irq_set", 128'(o_msg_interrupt), 128'(1'b1));

    intr_en = '0;
    @(posedge clk); #1;
    chk("irq_masked", 128'(o_msg_interrupt), 128'(1'b0));
    intr_en = '1;
    @(posedge clk); #1;
    chk("irq_unmasked", 128'(o_msg_interrupt), 128'(1'b1));

    send(8'h12, 1'b1, 3'd3, 62, 32'h0);
    chk("reuse_data_wptr", 128'(q_data_wptr), 128'(32'h0000_0003));

    for (int i = 1; i < NQ; i++) send(8'(8'h20 + i), 1'b0, 3'(i), i + 1, 32'h0);
    chk("all_status", 128'(q_intr_status), 128'(32'h0000_7FFF));
    send(8'hEE, 1'b1, 3'd7, 9, 32'h0);
    chk("drop_cnt_one", 128'(dbg[31:24]), 128'(8'd1));

    send(8'h22, 1'b0, 3'd2, 3, 32'h0000_0004);
    chk("clr_vs_set_bit2", 128'(q_intr_status[2]), 128'(1'b1));
    apply_clear(32'h0000_0004);
    chk("clear_bit2", 128'(q_intr_status[2]), 128'(1'b0));
    send(8'h99, 1'b1, 3'd5, 7, 32'h0);
    chk("realloc_q2", 128'(q_data_wptr), 128'(32'h0200_000D));
    apply_clear(32'hFFFF_8000);

    send(8'h55, 1'b0, 3'd0, 0, 32'h0);
    send(8'h55, 1'b0, 3'd0, 65, 32'h0);
    chk("len_err_two", 128'(dbg[23:16]), 128'(8'd2));
    for (int i = 0; i < 298; i++) send(8'h55, 1'b0, 3'd0, (i % 2 == 1) ? 65 + i : 0, 32'h0);
    chk("len_err_sat", 128'(dbg[23:16]), 128'(8'd255));

    apply_clear({17'b0, {NQ{1'b1}}});
    chk("irq_lags_clear", 128'(o_msg_interrupt), 128'(1'b1));
    @(posedge clk); #1;
    chk("irq_after_clear", 128'(o_msg_interrupt), 128'(1'b0));

    evt_src_id = 8'h33;
    evt_to     = 1'b0;
    evt_tag    = 3'd4;
    evt_len    = 12'd8;
    evt_valid  = 1'b1;
    @(posedge clk); #1;
    evt_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("mid_reset");
    chk("mid_reset_irq", 128'(o_msg_interrupt), 128'(1'b0));
    chk("mid_reset_data_wptr", 128'(q_data_wptr), 128'(32'h0));
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send(8'h77, 1'b0, 3'd1, 4, 32'h0);
    chk("post_reset_q0", 128'(q_data_wptr), 128'(32'h0000_0004));
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
